adder_stream_receiver: RTL and testbench
========================================

Name: adder_stream_receiver

Overview:
- Receiving end of the time-multiplexed sum/carry stream produced by the team's adder sequencing FSM (idle, then repeating sum-only, carry-only and sum+carry phases).
- Tracks the same phase sequence from the shared start/rst controls.
- Checks the stream for protocol violations and packs the {COUT,S} pairs from the sum+carry phase into DATA_W-bit words.
- Delivers words on a valid/ready interface to downstream logic.

Parameters:
DATA_W, 8, output word width; even, >= 2; DATA_W/2 frames per word
REG_LAT, 0, stream latency behind phase: 0 = unregistered transmitter outputs, 1 = registered transmitter outputs (one cycle late)
FCNT_W, 8, width of completed-frame counter

Ports:
CLK  in  1  clock
NRST  in  1  asynchronous active-low reset
rst  in  1  synchronous abort, same signal the transmitter sees
start  in  1  start, same signal the transmitter sees
S  in  1  serial sum bit
COUT  in  1  serial carry bit
clr  in  1  synchronous clear of sticky flags
out_ready  in  1  downstream accepts word
out_valid  out  1  out_data holds a completed word
out_data  out  DATA_W  packed word
proto_err  out  1  sticky protocol violation
overflow  out  1  sticky dropped-word flag
frame_cnt  out  FCNT_W  completed frames, wraps

Behaviour:
- Reset (NRST low, async): state=IDLE; shift register, pair counter and delayed phase = 0; all outputs = 0.
- Phase FSM (2-bit), advances every CLK:
  - IDLE: start -> P1, else IDLE; rst ignored.
  - P1: rst -> IDLE, else P2.
  - P2: rst -> IDLE, else P3.
  - P3: rst -> IDLE, else P1.
  - start and rst together in IDLE -> P1.
- Sample phase:
  - REG_LAT=0: the current state.
  - REG_LAT=1: the state registered one cycle; reset value IDLE.
  - S/COUT are interpreted against the sample phase in the same cycle.
- Protocol checks, per cycle, by sample phase:
  - IDLE: S and COUT must be 0.
  - P1: COUT must be 0; S is don't-care.
  - P2: S must be 0; COUT is don't-care.
  - Any violation sets proto_err on the next edge. It stays set until clr=1 or NRST; if clr and a violation occur in the same cycle, set wins.
- Packing, on a P3 sample:
  - sh <= {sh[DATA_W-3:0], COUT, S}; the first frame ends up in the MSBs.
  - pair counter increments; frame_cnt increments (wraps modulo 2^FCNT_W).
  - When the pair counter = DATA_W/2-1, the word is complete and the counter wraps to 0.
- Output register:
  - Complete word with out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: out_data <= completed word, out_valid <= 1 next edge.
  - Complete word with out_valid=1 and out_ready=0: word dropped, overflow set (sticky, clr/NRST clear, set wins over clr), out_data unchanged.
  - out_valid=1 and out_ready=1 with no new word: out_valid <= 0; out_data holds its last value.
  - Latency: out_valid rises on the edge after the last P3 sample.
- Abort (rst=1 while state != IDLE):
  - The shift register and pair counter clear next edge. The current cycle's sample is not packed.
  - REG_LAT=1: the delayed sample in the following cycle is also discarded and not checked.
  - The pending out_valid word and frame_cnt are unaffected.
- No packing occurs from IDLE samples; a partial word persists across P1/P2 phases.

Test Plan:
1. REG_LAT=0, DATA_W=8: start pulse, then 4 frames with P1 S=1/COUT=0, P2 S=0/COUT=1, P3 {COUT,S}=11,01,10,00 -> out_valid=1 the cycle after the 4th P3; out_data=0xD8; frame_cnt=4; proto_err=0.
2. COUT=1 during P1 of frame 1 -> proto_err=1 from the next cycle, held through later frames; clr pulse -> proto_err=0.
3. out_ready=0, 8 frames: first word 0xD8, second word 0x27 -> out_valid stays 1, out_data=0xD8, overflow=1. Then out_ready=1 for one cycle -> out_valid=0.
4. Two frames (P3 pairs 11,11), then rst during P2 of frame 3 -> IDLE; start, 4 frames of 00,01,10,11 -> out_data=0x1B, with no residue from the aborted frames.
5. REG_LAT=1, stimulus from test 1 delayed one cycle -> out_data=0xD8, out_valid one cycle later than in test 1, no proto_err.
6. NRST low mid-frame with out_valid=1 and proto_err=1 -> out_valid, out_data, proto_err, overflow and frame_cnt are 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/adder_stream_receiver_if.sv
// Stream and word handshake between the adder transmitter, this receiver and downstream.
// The slave side is the receiver; the master side drives the stream and out_ready.
interface adder_stream_receiver_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              S;
  logic              COUT;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  start, S, COUT, out_ready,
    output out_valid, out_data
  );

  modport master (
    output start, S, COUT, out_ready,
    input  out_valid, out_data
  );
endinterface

// File: rtl/adder_stream_receiver.sv
// Follows the transmitter's IDLE/P1/P2/P3 phase sequence, checks the serial sum/carry stream
// and packs the {COUT,S} pairs from P3 into DATA_W-bit words for a valid/ready consumer.
module adder_stream_receiver #(
  parameter int DATA_W  = 8,
  parameter int REG_LAT = 0,
  parameter int FCNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic                  rst,
  input  logic                  clr,
  adder_stream_receiver_if.slave bus,
  output logic                  proto_err,
  output logic                  overflow,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam int FRAMES = DATA_W / 2;
  localparam int PCNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(FRAMES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} phase_t;

  phase_t              state, state_nxt, phase_p1, samp;
  logic                abort_p0, abort_p1;
  logic                chk_en, pack, done, viol;
  logic [DATA_W-1:0]   sh, word;
  logic [PCNT_W-1:0]   pcnt;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;

  function automatic logic stream_viol(input phase_t ph, input logic s, input logic c);
    case (ph)
      IDLE:    return s | c;
      P1:      return c;
      P2:      return s;
      default: return 1'b0;
    endcase
  endfunction

  // Phase FSM, mirrors the transmitter from the shared start/rst controls
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = P1;
      P1:      state_nxt = rst ? IDLE : P2;
      P2:      state_nxt = rst ? IDLE : P3;
      P3:      state_nxt = rst ? IDLE : P1;
      default: state_nxt = IDLE;
    endcase
  end

  assign abort_p0 = rst && (state != IDLE);

  // Stage p1: phase delayed to line up with a registered transmitter
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      phase_p1 <= IDLE;
      abort_p1 <= 1'b0;
    end else begin
      phase_p1 <= state;
      abort_p1 <= abort_p0;
    end
  end

  // With a registered transmitter the sample right after an abort still belongs to the dead run
  assign samp   = (REG_LAT != 0) ? phase_p1 : state;
  assign chk_en = !((REG_LAT != 0) && abort_p1);
  assign viol   = chk_en && stream_viol(samp, bus.S, bus.COUT);
  assign pack   = chk_en && !abort_p0 && (samp == P3);
  assign done   = pack && (pcnt == PCNT_LAST);
  assign word   = DATA_W'({sh, bus.COUT, bus.S});

  // Packing stage: first frame shifts up into the MSBs
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sh        <= '0;
      pcnt      <= '0;
      frame_cnt <= '0;
    end else begin
      if (abort_p0) begin
        sh   <= '0;
        pcnt <= '0;
      end else if (pack) begin
        sh   <= word;
        pcnt <= done ? '0 : pcnt + 1'b1;
      end
      if (pack) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Output stage and sticky status; a new set always beats clr
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      proto_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (done && (!valid_q || bus.out_ready)) begin
        valid_q <= 1'b1;
        data_q  <= word;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end

      if (viol)     proto_err <= 1'b1;
      else if (clr) proto_err <= 1'b0;

      if (done && valid_q && !bus.out_ready) overflow <= 1'b1;
      else if (clr)                          overflow <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_adder_stream_receiver.sv
// Directed and randomized stream bench for adder_stream_receiver, unregistered and registered stream variants.
module tb_adder_stream_receiver;
  localparam int DW = 8;
  localparam int FW = 8;
  localparam int PH_IDLE = 0, PH_1 = 1, PH_2 = 2, PH_3 = 3;

  logic CLK = 1'b0;
  logic NRST, rst, clr;
  logic perr0, ovf0, perr1, ovf1;
  logic [FW-1:0] fc0, fc1;
  logic s_d = 1'b0, c_d = 1'b0;

  always #5 CLK = ~CLK;

  adder_stream_receiver_if #(.DATA_W(DW)) if0 ();
  adder_stream_receiver_if #(.DATA_W(DW)) if1 ();

  // Second receiver sees the same stream one cycle late, as from a registered transmitter
  always @(posedge CLK) begin
    s_d <= if0.S;
    c_d <= if0.COUT;
  end
  assign if1.S         = s_d;
  assign if1.COUT      = c_d;
  assign if1.start     = if0.start;
  assign if1.out_ready = if0.out_ready;

  adder_stream_receiver #(.DATA_W(DW), .REG_LAT(0), .FCNT_W(FW)) u0 (
    .CLK(CLK), .NRST(NRST), .rst(rst), .clr(clr), .bus(if0),
    .proto_err(perr0), .overflow(ovf0), .frame_cnt(fc0));

  adder_stream_receiver #(.DATA_W(DW), .REG_LAT(1), .FCNT_W(FW)) u1 (
    .CLK(CLK), .NRST(NRST), .rst(rst), .clr(clr), .bus(if1),
    .proto_err(perr1), .overflow(ovf1), .frame_cnt(fc1));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for the unregistered receiver, kept at frame/word level
  bit         m_valid, m_ovf, m_perr;
  logic [7:0] m_data;
  int         m_fcnt;
  logic [1:0] m_pairs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ovf = 0; m_perr = 0; m_data = '0; m_fcnt = 0;
    m_pairs.delete();
  endtask

  task automatic check_u0(input string tag);
    chk({tag, ".valid"}, 32'(if0.out_valid), 32'(m_valid));
    chk({tag, ".data"},  32'(if0.out_data),  32'(m_data));
    chk({tag, ".perr"},  32'(perr0),         32'(m_perr));
    chk({tag, ".ovf"},   32'(ovf0),          32'(m_ovf));
    chk({tag, ".fcnt"},  32'(fc0),           32'(m_fcnt));
  endtask

  // One clock of stimulus; ph is the phase the bench intends this cycle to be
  task automatic tick(input int ph, input bit st, input bit ab, input bit s, input bit c);
    bit viol, done, ovf_set;
    logic [7:0] w;
    if0.start = st; rst = ab; if0.S = s; if0.COUT = c;
    viol = (ph == PH_IDLE && (s || c)) || (ph == PH_1 && c) || (ph == PH_2 && s);
    done = 0; w = '0;
    if (ab && ph != PH_IDLE) m_pairs.delete();
    else if (ph == PH_3) begin
      m_pairs.push_back({c, s});
      m_fcnt = (m_fcnt + 1) % (1 << FW);
      if (m_pairs.size() == DW / 2) begin
        foreach (m_pairs[i]) w = {w[5:0], m_pairs[i]};
        m_pairs.delete();
        done = 1;
      end
    end
    ovf_set = done && m_valid && !if0.out_ready;
    if (done && !ovf_set) begin m_valid = 1; m_data = w; end
    else if (!done && m_valid && if0.out_ready) m_valid = 0;
    if (viol) m_perr = 1; else if (clr) m_perr = 0;
    if (ovf_set) m_ovf = 1; else if (clr) m_ovf = 0;
    @(posedge CLK); #1;
  endtask

  task automatic frame(input logic [1:0] p);
    tick(PH_1, 0, 0, 1, 0);
    tick(PH_2, 0, 0, 0, 1);
    tick(PH_3, 0, 0, p[0], p[1]);
  endtask

  // Leave the running sequence: quiet P1, then abort in P2
  task automatic end_run();
    tick(PH_1, 0, 0, 0, 0);
    tick(PH_2, 0, 1, 0, 0);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit b1, b2;
    logic [1:0] rp;
    NRST = 0; rst = 0; clr = 0;
    if0.start = 0; if0.S = 0; if0.COUT = 0; if0.out_ready = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_u0("reset");
    chk("reset.u1.valid", 32'(if1.out_valid), 32'd0);
    NRST = 1;
    tick(PH_IDLE, 0, 0, 0, 0);

    // Test 1: one word, out_ready low
    tick(PH_IDLE, 1, 0, 0, 0);
    frame(2'b11); frame(2'b01); frame(2'b10);
    check_u0("t1.partial");
    frame(2'b00);
    check_u0("t1.word");
    chk("t1.const", 32'(if0.out_data), 32'hD8);
    end_run();

    // Test 2: carry in P1 is flagged and held; clr racing a violation loses
    if0.out_ready = 1;
    tick(PH_IDLE, 0, 0, 0, 0);
    check_u0("t2.drain");
    tick(PH_IDLE, 1, 0, 0, 0);
    tick(PH_1, 0, 0, 1, 1);
    check_u0("t2.err");
    tick(PH_2, 0, 0, 0, 1);
    tick(PH_3, 0, 0, 0, 0);
    frame(2'b01); frame(2'b10); frame(2'b11);
    check_u0("t2.held");
    end_run();
    clr = 1;
    tick(PH_IDLE, 0, 0, 1, 0);
    check_u0("t2.clr_vs_set");
    tick(PH_IDLE, 0, 0, 0, 0);
    clr = 0;
    check_u0("t2.clr");

    // Test 3: second word dropped while the first is unaccepted
    if0.out_ready = 0;
    tick(PH_IDLE, 1, 0, 0, 0);
    frame(2'b11); frame(2'b01); frame(2'b10); frame(2'b00);
    frame(2'b00); frame(2'b10); frame(2'b01); frame(2'b11);
    check_u0("t3.ovf");
    chk("t3.const", 32'(if0.out_data), 32'hD8);
    end_run();
    if0.out_ready = 1;
    tick(PH_IDLE, 0, 0, 0, 0);
    if0.out_ready = 0;
    check_u0("t3.accept");
    clr = 1;
    tick(PH_IDLE, 0, 0, 0, 0);
    clr = 0;
    check_u0("t3.clr");

    // Test 4: abort mid-frame leaves no residue
    tick(PH_IDLE, 1, 0, 0, 0);
    frame(2'b11); frame(2'b11);
    tick(PH_1, 0, 0, 1, 0);
    tick(PH_2, 0, 1, 0, 1);
    rst = 0;
    check_u0("t4.abort");
    tick(PH_IDLE, 1, 0, 0, 0);
    frame(2'b00); frame(2'b01); frame(2'b10); frame(2'b11);
    check_u0("t4.word");
    chk("t4.const", 32'(if0.out_data), 32'h1B);
    end_run();

    // Randomized frames with random don't-care bits and random out_ready
    tick(PH_IDLE, 1, 0, 0, 0);
    for (int f = 0; f < 24; f++) begin
      if0.out_ready = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      b2 = 1'($urandom_range(0, 1));
      rp = 2'($urandom_range(0, 3));
      tick(PH_1, 0, 0, b1, 0);
      tick(PH_2, 0, 0, 0, b2);
      tick(PH_3, 0, 0, rp[0], rp[1]);
      check_u0("rand");
    end
    end_run();
    if0.out_ready = 0;

    // Test 6: async reset mid-frame with valid and proto_err set
    tick(PH_IDLE, 0, 0, 1, 0);
    if (!m_valid) begin
      tick(PH_IDLE, 1, 0, 0, 0);
      frame(2'b10); frame(2'b01); frame(2'b11); frame(2'b00);
      tick(PH_1, 0, 0, 0, 1);
    end else begin
      tick(PH_IDLE, 1, 0, 0, 0);
      tick(PH_1, 0, 0, 1, 0);
    end
    check_u0("t6.pre");
    #1;
    NRST = 0;
    if0.start = 0; if0.S = 0; if0.COUT = 0;
    #2;
    model_reset();
    check_u0("t6.async");
    chk("t6.u1.valid", 32'(if1.out_valid), 32'd0);
    chk("t6.u1.fcnt",  32'(fc1),           32'd0);
    chk("t6.u1.perr",  32'(perr1),         32'd0);
    @(posedge CLK); #1;
    NRST = 1;
    tick(PH_IDLE, 0, 0, 0, 0);

    // Test 5: registered-stream receiver, word one cycle later
    tick(PH_IDLE, 1, 0, 0, 0);
    frame(2'b11); frame(2'b01); frame(2'b10); frame(2'b00);
    check_u0("t5.u0");
    chk("t5.u1.early_valid", 32'(if1.out_valid), 32'd0);
    tick(PH_1, 0, 0, 0, 0);
    chk("t5.u1.valid", 32'(if1.out_valid), 32'd1);
    chk("t5.u1.data",  32'(if1.out_data),  32'hD8);
    chk("t5.u1.fcnt",  32'(fc1),           32'd4);
    chk("t5.u1.perr",  32'(perr1),         32'd0);
    tick(PH_2, 0, 1, 0, 0);
    rst = 0;
    tick(PH_IDLE, 0, 0, 0, 0);
    chk("t5.u1.perr_after_abort", 32'(perr1), 32'd0);
    chk("t5.u1.ovf", 32'(ovf1), 32'd0);
    check_u0("t5.u0.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
